// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_hazard_ctrl_pkg                                                  |
// | Shared encodings for the pipeline hazard controller.                  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fwd_unit                                                              |
// | Combinational EX operand source select for one ALU operand.           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_ex_rs,
    input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
    input  logic                  i_mem_reg_we,
    input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
    input  logic                  i_wb_reg_we,
    output logic [1:0]            o_fwd_sel
);

    // The younger producer (ALU_MEM) holds the newest value, so it wins.
    always_comb begin
        o_fwd_sel = FWD_RF;
        if (i_ex_rs != X0_ADDR) begin
            if (i_mem_reg_we && (i_mem_rd_addr == i_ex_rs)) begin
                o_fwd_sel = FWD_MEM;
            end else if (i_wb_reg_we && (i_wb_rd_addr == i_ex_rs)) begin
                o_fwd_sel = FWD_WB;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_hazard_ctrl                                                      |
// | Stall/flush/bubble sequencing, operand forwarding and hazard counters.|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = 32,
    parameter int CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_reg_we,
    input  logic                  ex_is_load,
    input  logic                  ex_multicycle,
    input  logic                  ex_branch_taken,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_reg_we,
    input  logic [REG_ADDR_W-1:0] wb_rd_addr,
    input  logic                  wb_reg_we,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_stall,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  exmem_bubble,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  mc_busy,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int MC_CNT_W  = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
    localparam int MC_INIT   = (MC_CYCLES > 1) ? (MC_CYCLES - 2) : 0;
    localparam bit MC_STALLS = (MC_CYCLES > 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [MC_CNT_W-1:0]   r_mc_cnt;
    logic [MC_CNT_W-1:0]   w_mc_cnt_next;
    logic [REG_ADDR_W-1:0] r_ex_rs1;
    logic [REG_ADDR_W-1:0] r_ex_rs2;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;
    logic                  w_load_use;

    assign w_load_use = ex_is_load && ex_reg_we && (ex_rd_addr != X0_ADDR) &&
                        ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                         (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_mc_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_mc_cnt <= w_mc_cnt_next;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_mc_cnt_next = r_mc_cnt;
        pc_stall      = 1'b0;
        ifid_stall    = 1'b0;
        idex_stall    = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_bubble  = 1'b0;
        mc_busy       = 1'b0;
        if (rst) begin
            // Keep NOPs flowing into every stage while the core is held.
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (ex_multicycle && MC_STALLS) begin
                        pc_stall      = 1'b1;
                        ifid_stall    = 1'b1;
                        idex_stall    = 1'b1;
                        exmem_bubble  = 1'b1;
                        w_mc_cnt_next = MC_CNT_W'(MC_INIT);
                        w_next_state  = ST_MC_WAIT;
                    end else if (w_load_use) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                ST_MC_WAIT: begin
                    // Final cycle of the op: no stall, so the result advances.
                    if (r_mc_cnt != '0) begin
                        pc_stall      = 1'b1;
                        ifid_stall    = 1'b1;
                        idex_stall    = 1'b1;
                        exmem_bubble  = 1'b1;
                        mc_busy       = 1'b1;
                        w_mc_cnt_next = r_mc_cnt - 1'b1;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    // Shadow of the EX-stage sources tracks what the DEC_ALU register captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_rs1 <= '0;
            r_ex_rs2 <= '0;
        end else if (idex_bubble) begin
            r_ex_rs1 <= '0;
            r_ex_rs2 <= '0;
        end else if (!idex_stall) begin
            r_ex_rs1 <= id_rs1_used ? id_rs1_addr : X0_ADDR;
            r_ex_rs2 <= id_rs2_used ? id_rs2_addr : X0_ADDR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ifid_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

    fwd_unit u_fwd_a (
        .i_ex_rs       (r_ex_rs1),
        .i_mem_rd_addr (mem_rd_addr),
        .i_mem_reg_we  (mem_reg_we),
        .i_wb_rd_addr  (wb_rd_addr),
        .i_wb_reg_we   (wb_reg_we),
        .o_fwd_sel     (fwd_a_sel)
    );

    fwd_unit u_fwd_b (
        .i_ex_rs       (r_ex_rs2),
        .i_mem_rd_addr (mem_rd_addr),
        .i_mem_reg_we  (mem_reg_we),
        .i_wb_rd_addr  (wb_rd_addr),
        .i_wb_reg_we   (wb_reg_we),
        .o_fwd_sel     (fwd_b_sel)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl                                                   |
// | Directed self-checking bench for pipe_hazard_ctrl (MC_CYCLES = 4).    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    localparam int MC_CYCLES = 4;
    localparam int CNT_W     = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic             id_rs1_used, id_rs2_used, ex_reg_we, ex_is_load, ex_multicycle;
    logic             ex_branch_taken, mem_reg_we, wb_reg_we;
    logic             pc_stall, ifid_stall, idex_stall, ifid_flush, idex_bubble, exmem_bubble;
    logic             mc_busy;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       ctrl;

    int n_checks = 0;
    int n_errors = 0;

    // {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_bubble, exmem_bubble, mc_busy}
    assign ctrl = {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_bubble, exmem_bubble, mc_busy};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MC_CYCLES(MC_CYCLES), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rd_addr      (ex_rd_addr),
        .ex_reg_we       (ex_reg_we),
        .ex_is_load      (ex_is_load),
        .ex_multicycle   (ex_multicycle),
        .ex_branch_taken (ex_branch_taken),
        .mem_rd_addr     (mem_rd_addr),
        .mem_reg_we      (mem_reg_we),
        .wb_rd_addr      (wb_rd_addr),
        .wb_reg_we       (wb_reg_we),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .idex_stall      (idex_stall),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .exmem_bubble    (exmem_bubble),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .mc_busy         (mc_busy),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic clear_inputs();
        id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd_addr = 0; ex_reg_we = 0; ex_is_load = 0; ex_multicycle = 0;
        ex_branch_taken = 0; mem_rd_addr = 0; mem_reg_we = 0;
        wb_rd_addr = 0; wb_reg_we = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (ctrl !== 7'b0001110) begin
            n_errors++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 7'b0001110);
        end
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_fwd got=%b exp=0000", {fwd_a_sel, fwd_b_sel});
        end
        n_checks++;
        if (stall_cnt !== 0 || flush_cnt !== 0) begin
            n_errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 7'b0000000) begin
            n_errors++; $display("FAIL release_ctrl got=%b exp=0000000", ctrl);
        end
    endtask

    // lw x5 in EX, add x6,x5,x1 in decode.
    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        ex_is_load = 1; ex_reg_we = 1; ex_rd_addr = 5;
        id_rs1_addr = 5; id_rs1_used = 1; id_rs2_addr = 1; id_rs2_used = 1;
        #1;
        n_checks++;
        if (ctrl !== 7'b1100100) begin
            n_errors++; $display("FAIL loaduse_stall got=%b exp=1100100", ctrl);
        end
        @(negedge clk);
        ex_is_load = 0; ex_reg_we = 0; ex_rd_addr = 0;
        mem_rd_addr = 5; mem_reg_we = 1;
        #1;
        n_checks++;
        if (ctrl !== 7'b0000000 || fwd_a_sel !== 2'b00) begin
            n_errors++; $display("FAIL loaduse_bubble got=%b/%b exp=0000000/00", ctrl, fwd_a_sel);
        end
        @(negedge clk);
        mem_rd_addr = 0; mem_reg_we = 0; wb_rd_addr = 5; wb_reg_we = 1;
        id_rs1_used = 0; id_rs2_used = 0;
        #1;
        n_checks++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00) begin
            n_errors++; $display("FAIL loaduse_fwd got=%b/%b exp=10/00", fwd_a_sel, fwd_b_sel);
        end
        n_checks++;
        if (stall_cnt !== 1) begin
            n_errors++; $display("FAIL loaduse_stallcnt got=%0d exp=1", stall_cnt);
        end
    endtask

    task automatic test_fwd_priority();
        @(negedge clk);
        clear_inputs();
        id_rs1_addr = 7; id_rs1_used = 1; id_rs2_addr = 3; id_rs2_used = 1;
        @(negedge clk);
        mem_rd_addr = 7; mem_reg_we = 1; wb_rd_addr = 7; wb_reg_we = 1;
        #1;
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) begin
            n_errors++; $display("FAIL fwd_mem_wins got=%b exp=0100", {fwd_a_sel, fwd_b_sel});
        end
        mem_reg_we = 0;
        #1;
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) begin
            n_errors++; $display("FAIL fwd_wb_only got=%b exp=1000", {fwd_a_sel, fwd_b_sel});
        end
        mem_rd_addr = 3; mem_reg_we = 1;
        #1;
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b1001) begin
            n_errors++; $display("FAIL fwd_split got=%b exp=1001", {fwd_a_sel, fwd_b_sel});
        end
        mem_rd_addr = 9; wb_reg_we = 0;
        #1;
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            n_errors++; $display("FAIL fwd_nomatch got=%b exp=0000", {fwd_a_sel, fwd_b_sel});
        end
        // x0 source and an unused source must never forward.
        @(negedge clk);
        clear_inputs();
        id_rs1_addr = 0; id_rs1_used = 1; id_rs2_addr = 7; id_rs2_used = 0;
        @(negedge clk);
        mem_rd_addr = 0; mem_reg_we = 1; wb_rd_addr = 7; wb_reg_we = 1;
        #1;
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            n_errors++; $display("FAIL fwd_x0_unused got=%b exp=0000", {fwd_a_sel, fwd_b_sel});
        end
    endtask

    task automatic test_multicycle();
        logic [CNT_W-1:0] s0, f0;
        @(negedge clk);
        clear_inputs();
        s0 = stall_cnt; f0 = flush_cnt;
        ex_multicycle = 1;
        #1;
        n_checks++;
        if (ctrl !== 7'b1110010) begin
            n_errors++; $display("FAIL mc_cycle1 got=%b exp=1110010", ctrl);
        end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            // Redirect and load-use must be ignored while waiting.
            ex_branch_taken = (c == 3);
            ex_is_load = 1; ex_reg_we = 1; ex_rd_addr = 4;
            id_rs1_addr = 4; id_rs1_used = 1;
            #1;
            n_checks++;
            if (ctrl !== 7'b1110011) begin
                n_errors++; $display("FAIL mc_cycle%0d got=%b exp=1110011", c, ctrl);
            end
        end
        @(negedge clk);
        ex_branch_taken = 0; ex_is_load = 0; ex_reg_we = 0; id_rs1_used = 0;
        #1;
        n_checks++;
        if (ctrl !== 7'b0000000) begin
            n_errors++; $display("FAIL mc_cycle4 got=%b exp=0000000", ctrl);
        end
        n_checks++;
        if (stall_cnt !== s0 + 3 || flush_cnt !== f0) begin
            n_errors++; $display("FAIL mc_counts got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, s0 + 3, f0);
        end
        @(negedge clk);
        ex_multicycle = 0;
        #1;
        n_checks++;
        if (ctrl !== 7'b0000000 || stall_cnt !== s0 + 3) begin
            n_errors++; $display("FAIL mc_after got=%b/%0d exp=0000000/%0d", ctrl, stall_cnt, s0 + 3);
        end
    endtask

    task automatic test_redirect_loaduse();
        logic [CNT_W-1:0] s0, f0;
        @(negedge clk);
        clear_inputs();
        s0 = stall_cnt; f0 = flush_cnt;
        ex_branch_taken = 1;
        ex_is_load = 1; ex_reg_we = 1; ex_rd_addr = 8;
        id_rs2_addr = 8; id_rs2_used = 1;
        #1;
        n_checks++;
        if (ctrl !== 7'b0001100) begin
            n_errors++; $display("FAIL redir_ctrl got=%b exp=0001100", ctrl);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (flush_cnt !== f0 + 1 || stall_cnt !== s0) begin
            n_errors++; $display("FAIL redir_counts got=%0d/%0d exp=%0d/%0d", flush_cnt, stall_cnt, f0 + 1, s0);
        end
    endtask

    task automatic test_reset_mid_mc();
        @(negedge clk);
        clear_inputs();
        ex_multicycle = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (ctrl !== 7'b1110011) begin
            n_errors++; $display("FAIL rstmc_pre got=%b exp=1110011", ctrl);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 7'b0001110 || stall_cnt !== 0 || flush_cnt !== 0) begin
            n_errors++; $display("FAIL rstmc_async got=%b/%0d/%0d exp=0001110/0/0", ctrl, stall_cnt, flush_cnt);
        end
        @(negedge clk);
        ex_multicycle = 0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 7'b0000000) begin
            n_errors++; $display("FAIL rstmc_release got=%b exp=0000000", ctrl);
        end
        // In RUN a load-use gives a one-cycle bubble, not an MC_WAIT hold.
        @(negedge clk);
        ex_is_load = 1; ex_reg_we = 1; ex_rd_addr = 2;
        id_rs1_addr = 2; id_rs1_used = 1;
        #1;
        n_checks++;
        if (ctrl !== 7'b1100100) begin
            n_errors++; $display("FAIL rstmc_run got=%b exp=1100100", ctrl);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_checks++;
        if (stall_cnt !== 1) begin
            n_errors++; $display("FAIL rstmc_stallcnt got=%0d exp=1", stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_multicycle();
        test_redirect_loaduse();
        test_reset_mid_mc();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
